spu_reg_fetch: RTL and testbench
================================

SPU_REG_FETCH -- requirements
Module: spu_reg_fetch

Interface
REQ-001 The block SHALL have ports `clk` (in, 1, clock) and `reset` (in, 1, reset, synchronous, active-high), listed first.
REQ-002 The block SHALL have input `stall` (1): hold the issue register.
REQ-003 The block SHALL have input `flush` (1): replace the issue register contents with a nop.
REQ-004 The block SHALL have inputs `ra_addr`, `rb_addr`, `rc_addr` (each [0:6]): source register addresses.
REQ-005 The block SHALL have decoded-instruction inputs `op_in` [0:10], `format_in` [2:0], `rt_addr_in` [0:6], `imm_in` [0:17] and `reg_write_in` (1).
REQ-006 The block SHALL have writeback port E, made of inputs `rt_wb_e` [0:127], `rt_addr_wb_e` [0:6] and `reg_write_wb_e` (1).
REQ-007 The block SHALL have writeback port O, made of inputs `rt_wb_o` [0:127], `rt_addr_wb_o` [0:6] and `reg_write_wb_o` (1).
REQ-008 The block SHALL have outputs `op`, `format`, `rt_addr`, `imm` and `reg_write` (widths as the inputs): the registered instruction fields.
REQ-009 The block SHALL have outputs `ra`, `rb`, `rc` (each [0:127]): the registered operand values.

Function
REQ-010 The block SHALL hold a register table of 128 entries × 128 bits, with 3 read ports and 2 write ports.
REQ-011 On each posedge with `reg_write_wb_e`=1, entry `rt_addr_wb_e` SHALL take the value `rt_wb_e`; port O SHALL behave the same way.
REQ-012 When both write ports target the same address in the same cycle, port O SHALL win.
REQ-013 All outputs SHALL be registered, with 1-cycle latency from address/field input to output.
REQ-014 With `stall`=0 and `flush`=0, each posedge SHALL load the fields from the `*_in` inputs and the operands from table[ra_addr], table[rb_addr] and table[rc_addr].
REQ-015 With `stall`=1 and `flush`=0, the instruction fields SHALL hold.
REQ-016 With `stall`=1 and `flush`=0, the operands SHALL be re-read each cycle using the held source addresses, so that writes landing during a stall become visible.
REQ-017 With `flush`=1, the next posedge SHALL load a nop: `op`=0, `format`=0, `rt_addr`=0, `imm`=0, `reg_write`=0, and operands 0.
REQ-018 `flush` SHALL take priority over `stall`.
REQ-019 Writes SHALL never be blocked by `stall` or `flush`.
REQ-020 A write and a read of the same address in the same cycle SHALL be handled as defined under Configuration.
REQ-021 The block SHALL create no X on its outputs for any address value; all 7-bit addresses are valid.

Reset
REQ-022 On `reset`=1 at a posedge, all 128 table entries SHALL clear to 0.
REQ-023 On `reset`=1 at a posedge, all outputs SHALL clear to 0, which is a nop.
REQ-024 During reset, writes on port E and port O SHALL be ignored.
REQ-025 Reset SHALL take priority over `flush`, `stall` and writes.
REQ-026 Asserting reset mid-stall SHALL discard the held instruction.

Configuration
REQ-027 With macro `SPU_RF_BYPASS_EN` defined, a read whose address matches an enabled write in the same cycle SHALL return the write data.
REQ-028 Under `SPU_RF_BYPASS_EN`, if both ports match, the port O data SHALL be returned.
REQ-029 Bypass SHALL apply to all three read ports, in both normal and stalled re-read.
REQ-030 Without `SPU_RF_BYPASS_EN`, a same-cycle read SHALL return the pre-write value, and the new value SHALL be visible one cycle later.

Structure
REQ-031 A shared package `spu_pkg` SHALL define the widths: OP_W=11, ADDR_W=7, REG_W=128, IMM_W=18, FMT_W=3, NREGS=128.
REQ-032 `spu_pkg` SHALL define the nop constants (OP_NOP=0, FMT_NOP=0).
REQ-033 `spu_pkg` SHALL define a packed struct `spu_instr_t` with fields op, format, rt_addr, imm and reg_write.
REQ-034 The storage SHALL be one sub-module, `spu_reg_table`, with 3 read and 2 write ports, synchronous reset, and write-priority logic.
REQ-035 Bypass muxing and the issue register SHALL live in `spu_reg_fetch`.

Verification
REQ-036 Scenario: write port E r5=0xA5…A5 → next cycle read ra_addr=5 → `ra`=0xA5…A5 one cycle later.
REQ-037 Scenario: same cycle, port E and port O both write r9 (E=1, O=2) → a later read of r9 returns 2.
REQ-038 Scenario: in the same cycle, write r3=0x77 and read rb_addr=3 → `rb`=0x77 with `SPU_RF_BYPASS_EN`; old value 0 without it, then 0x77 on the following read.
REQ-039 Scenario: `stall` held 3 cycles with ra_addr latched=12 while port O writes r12=0x1234 → `ra` updates to 0x1234 and `op`/`imm` stay unchanged throughout.
REQ-040 Scenario: `stall`=1 and `flush`=1 together → next cycle all outputs 0, `reg_write`=0.
REQ-041 Scenario: fill r0–r127 with their index, assert `reset` for 1 cycle → all reads return 0 and all outputs 0.

Source files
------------

// File: rtl/spu_pkg.sv
// Shared SPU widths, nop encoding and the decoded-instruction record.
package spu_pkg;

    localparam int OP_W   = 11;
    localparam int ADDR_W = 7;
    localparam int REG_W  = 128;
    localparam int IMM_W  = 18;
    localparam int FMT_W  = 3;
    localparam int NREGS  = 128;

    localparam logic [0:OP_W-1]  OP_NOP  = '0;
    localparam logic [FMT_W-1:0] FMT_NOP = '0;

    typedef struct packed {
        logic [0:OP_W-1]   op;
        logic [FMT_W-1:0]  format;
        logic [0:ADDR_W-1] rt_addr;
        logic [0:IMM_W-1]  imm;
        logic              reg_write;
    } spu_instr_t;

    localparam spu_instr_t INSTR_NOP = '{
        op:        OP_NOP,
        format:    FMT_NOP,
        rt_addr:   '0,
        imm:       '0,
        reg_write: 1'b0
    };

endpackage

// File: rtl/spu_reg_table.sv
// 128 x 128-bit register table: three asynchronous read ports, two write ports
// (port O wins on an address collision), synchronous clear on reset.
module spu_reg_table
    import spu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [0:ADDR_W-1] rd_addr_a,
    input  logic [0:ADDR_W-1] rd_addr_b,
    input  logic [0:ADDR_W-1] rd_addr_c,
    output logic [0:REG_W-1]  rd_data_a,
    output logic [0:REG_W-1]  rd_data_b,
    output logic [0:REG_W-1]  rd_data_c,
    input  logic              we_e,
    input  logic [0:ADDR_W-1] wr_addr_e,
    input  logic [0:REG_W-1]  wr_data_e,
    input  logic              we_o,
    input  logic [0:ADDR_W-1] wr_addr_o,
    input  logic [0:REG_W-1]  wr_data_o
);

    logic [0:REG_W-1] regs [NREGS];
    logic             we_e_eff;

    // Port E is suppressed when port O targets the same entry.
    assign we_e_eff = we_e && !(we_o && (wr_addr_o == wr_addr_e));

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (we_e_eff) begin
                regs[wr_addr_e] <= wr_data_e;
            end
            if (we_o) begin
                regs[wr_addr_o] <= wr_data_o;
            end
        end
    end

    assign rd_data_a = regs[rd_addr_a];
    assign rd_data_b = regs[rd_addr_b];
    assign rd_data_c = regs[rd_addr_c];

endmodule

// File: rtl/spu_reg_fetch.sv
// SPU register-fetch stage: operand read plus issue register with stall/flush.
// Define SPU_RF_BYPASS_EN to forward same-cycle write data to the read ports.
module spu_reg_fetch
    import spu_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic [0:ADDR_W-1] ra_addr,
    input  logic [0:ADDR_W-1] rb_addr,
    input  logic [0:ADDR_W-1] rc_addr,
    input  logic [0:OP_W-1]   op_in,
    input  logic [FMT_W-1:0]  format_in,
    input  logic [0:ADDR_W-1] rt_addr_in,
    input  logic [0:IMM_W-1]  imm_in,
    input  logic              reg_write_in,
    input  logic [0:REG_W-1]  rt_wb_e,
    input  logic [0:ADDR_W-1] rt_addr_wb_e,
    input  logic              reg_write_wb_e,
    input  logic [0:REG_W-1]  rt_wb_o,
    input  logic [0:ADDR_W-1] rt_addr_wb_o,
    input  logic              reg_write_wb_o,
    output logic [0:OP_W-1]   op,
    output logic [FMT_W-1:0]  format,
    output logic [0:ADDR_W-1] rt_addr,
    output logic [0:IMM_W-1]  imm,
    output logic              reg_write,
    output logic [0:REG_W-1]  ra,
    output logic [0:REG_W-1]  rb,
    output logic [0:REG_W-1]  rc
);

    spu_instr_t        instr_q;
    logic [0:ADDR_W-1] ra_hold, rb_hold, rc_hold;
    logic [0:ADDR_W-1] ra_sel, rb_sel, rc_sel;
    logic [0:REG_W-1]  ra_tab, rb_tab, rc_tab;
    logic [0:REG_W-1]  ra_next, rb_next, rc_next;
    logic [0:REG_W-1]  ra_q, rb_q, rc_q;

    // While stalled, the operands are re-read from the held source addresses.
    assign ra_sel = stall ? ra_hold : ra_addr;
    assign rb_sel = stall ? rb_hold : rb_addr;
    assign rc_sel = stall ? rc_hold : rc_addr;

    spu_reg_table u_table (
        .clk       (clk),
        .reset     (reset),
        .rd_addr_a (ra_sel),
        .rd_addr_b (rb_sel),
        .rd_addr_c (rc_sel),
        .rd_data_a (ra_tab),
        .rd_data_b (rb_tab),
        .rd_data_c (rc_tab),
        .we_e      (reg_write_wb_e),
        .wr_addr_e (rt_addr_wb_e),
        .wr_data_e (rt_wb_e),
        .we_o      (reg_write_wb_o),
        .wr_addr_o (rt_addr_wb_o),
        .wr_data_o (rt_wb_o)
    );

`ifdef SPU_RF_BYPASS_EN
    function automatic logic [0:REG_W-1] bypass(input logic [0:ADDR_W-1] addr,
                                                input logic [0:REG_W-1]  tab_data);
        if (reg_write_wb_o && (rt_addr_wb_o == addr)) return rt_wb_o;
        if (reg_write_wb_e && (rt_addr_wb_e == addr)) return rt_wb_e;
        return tab_data;
    endfunction

    assign ra_next = bypass(ra_sel, ra_tab);
    assign rb_next = bypass(rb_sel, rb_tab);
    assign rc_next = bypass(rc_sel, rc_tab);
`else
    assign ra_next = ra_tab;
    assign rb_next = rb_tab;
    assign rc_next = rc_tab;
`endif

    // A flush leaves a nop with zero operands and zero held addresses.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            instr_q <= INSTR_NOP;
            ra_hold <= '0;
            rb_hold <= '0;
            rc_hold <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            rc_q    <= '0;
        end else begin
            if (!stall) begin
                instr_q <= '{op: op_in, format: format_in, rt_addr: rt_addr_in,
                             imm: imm_in, reg_write: reg_write_in};
                ra_hold <= ra_addr;
                rb_hold <= rb_addr;
                rc_hold <= rc_addr;
            end
            ra_q <= ra_next;
            rb_q <= rb_next;
            rc_q <= rc_next;
        end
    end

    assign op        = instr_q.op;
    assign format    = instr_q.format;
    assign rt_addr   = instr_q.rt_addr;
    assign imm       = instr_q.imm;
    assign reg_write = instr_q.reg_write;
    assign ra        = ra_q;
    assign rb        = rb_q;
    assign rc        = rc_q;

endmodule

// File: tb/tb_spu_reg_fetch.sv
// Scoreboard bench for spu_reg_fetch; follows SPU_RF_BYPASS_EN if defined.
module tb_spu_reg_fetch;
    import spu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset, stall, flush;
    logic [0:ADDR_W-1] ra_addr, rb_addr, rc_addr, rt_addr_in;
    logic [0:OP_W-1]   op_in;
    logic [FMT_W-1:0]  format_in;
    logic [0:IMM_W-1]  imm_in;
    logic              reg_write_in;
    logic [0:REG_W-1]  rt_wb_e, rt_wb_o;
    logic [0:ADDR_W-1] rt_addr_wb_e, rt_addr_wb_o;
    logic              reg_write_wb_e, reg_write_wb_o;
    logic [0:OP_W-1]   op;
    logic [FMT_W-1:0]  format;
    logic [0:ADDR_W-1] rt_addr;
    logic [0:IMM_W-1]  imm;
    logic              reg_write;
    logic [0:REG_W-1]  ra, rb, rc;

    spu_reg_fetch dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .ra_addr(ra_addr), .rb_addr(rb_addr), .rc_addr(rc_addr),
        .op_in(op_in), .format_in(format_in), .rt_addr_in(rt_addr_in),
        .imm_in(imm_in), .reg_write_in(reg_write_in),
        .rt_wb_e(rt_wb_e), .rt_addr_wb_e(rt_addr_wb_e), .reg_write_wb_e(reg_write_wb_e),
        .rt_wb_o(rt_wb_o), .rt_addr_wb_o(rt_addr_wb_o), .reg_write_wb_o(reg_write_wb_o),
        .op(op), .format(format), .rt_addr(rt_addr), .imm(imm), .reg_write(reg_write),
        .ra(ra), .rb(rb), .rc(rc)
    );

    typedef struct {
        logic [127:0] ra, rb, rc;
        logic [10:0]  op;
        logic [2:0]   format;
        logic [6:0]   rt_addr;
        logic [17:0]  imm;
        logic         reg_write;
    } exp_t;

    exp_t         exp_q[$];
    exp_t         cur;
    logic [127:0] mt [128];
    logic [6:0]   hra, hrb, hrc;
    int           total = 0;
    int           bad = 0;

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    function automatic logic [127:0] model_read(input logic [6:0] a);
`ifdef SPU_RF_BYPASS_EN
        if (reg_write_wb_o && (rt_addr_wb_o == a)) return rt_wb_o;
        if (reg_write_wb_e && (rt_addr_wb_e == a)) return rt_wb_e;
`endif
        return mt[a];
    endfunction

    // Predict the post-edge outputs, advance the model, clock, then score.
    task automatic applyStimulus();
        exp_t e;
        exp_t got;
        if (reset || flush) begin
            e = '{default: '0};
            hra = '0; hrb = '0; hrc = '0;
        end else begin
            if (stall) begin
                e = cur;
            end else begin
                e = '{default: '0};
                e.op = op_in; e.format = format_in; e.rt_addr = rt_addr_in;
                e.imm = imm_in; e.reg_write = reg_write_in;
                hra = ra_addr; hrb = rb_addr; hrc = rc_addr;
            end
            e.ra = model_read(hra);
            e.rb = model_read(hrb);
            e.rc = model_read(hrc);
        end
        if (reset) begin
            for (int i = 0; i < 128; i++) mt[i] = '0;
        end else begin
            if (reg_write_wb_e) mt[rt_addr_wb_e] = rt_wb_e;
            if (reg_write_wb_o) mt[rt_addr_wb_o] = rt_wb_o;
        end
        cur = e;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        checkOutput("op", op, got.op);
        checkOutput("format", format, got.format);
        checkOutput("rt_addr", rt_addr, got.rt_addr);
        checkOutput("imm", imm, got.imm);
        checkOutput("reg_write", reg_write, got.reg_write);
        checkOutput("ra", ra, got.ra);
        checkOutput("rb", rb, got.rb);
        checkOutput("rc", rc, got.rc);
    endtask

    task automatic idle();
        reset = 0; stall = 0; flush = 0;
        reg_write_wb_e = 0; reg_write_wb_o = 0;
        rt_wb_e = '0; rt_wb_o = '0; rt_addr_wb_e = '0; rt_addr_wb_o = '0;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        for (int i = 0; i < 128; i++) mt[i] = '0;
        cur = '{default: '0};
        hra = '0; hrb = '0; hrc = '0;
        idle();
        ra_addr = '0; rb_addr = '0; rc_addr = '0;
        op_in = '0; format_in = '0; rt_addr_in = '0; imm_in = '0; reg_write_in = 0;
        reset = 1;
        applyStimulus();
        applyStimulus();

        // Port E write then read back.
        idle();
        rt_wb_e = {16{8'hA5}}; rt_addr_wb_e = 7'd5; reg_write_wb_e = 1;
        applyStimulus();
        idle();
        ra_addr = 7'd5; op_in = 11'h123; format_in = 3'd5; rt_addr_in = 7'd33;
        imm_in = 18'h1F00F; reg_write_in = 1;
        applyStimulus();

        // Dual write collision on r9, port O must win.
        rt_wb_e = 128'd1; rt_addr_wb_e = 7'd9; reg_write_wb_e = 1;
        rt_wb_o = 128'd2; rt_addr_wb_o = 7'd9; reg_write_wb_o = 1;
        applyStimulus();
        idle();
        rb_addr = 7'd9;
        applyStimulus();

        // Same-cycle write/read of r3, then read again.
        rt_wb_e = 128'h77; rt_addr_wb_e = 7'd3; reg_write_wb_e = 1;
        rb_addr = 7'd3;
        applyStimulus();
        idle();
        applyStimulus();

        // Stall with a write landing on the held source address.
        ra_addr = 7'd12; op_in = 11'h155; imm_in = 18'h2ABCD; reg_write_in = 1;
        applyStimulus();
        stall = 1; ra_addr = 7'd0; op_in = 11'h7FF; imm_in = '0;
        rt_wb_o = 128'h1234; rt_addr_wb_o = 7'd12; reg_write_wb_o = 1;
        applyStimulus();
        reg_write_wb_o = 0;
        applyStimulus();
        applyStimulus();

        // Flush beats stall.
        stall = 1; flush = 1;
        applyStimulus();
        idle();
        applyStimulus();

        // Randomised traffic on a narrow address range to force collisions.
        for (int n = 0; n < 60; n++) begin
            reset = ($urandom_range(0, 29) == 0);
            flush = ($urandom_range(0, 7) == 0);
            stall = ($urandom_range(0, 2) == 0);
            ra_addr = 7'($urandom_range(0, 7));
            rb_addr = 7'($urandom_range(0, 7));
            rc_addr = 7'($urandom_range(120, 127));
            op_in = 11'($urandom); format_in = 3'($urandom); rt_addr_in = 7'($urandom);
            imm_in = 18'($urandom); reg_write_in = 1'($urandom);
            reg_write_wb_e = 1'($urandom); rt_addr_wb_e = 7'($urandom_range(0, 7));
            rt_wb_e = rand128();
            reg_write_wb_o = 1'($urandom);
            rt_addr_wb_o = ($urandom_range(0, 1) == 1) ? 7'($urandom_range(0, 7))
                                                       : 7'($urandom_range(120, 127));
            rt_wb_o = rand128();
            applyStimulus();
        end

        // Fill every entry with its index, then reset and read everything back.
        idle();
        for (int i = 0; i < 128; i += 2) begin
            rt_addr_wb_e = 7'(i);     rt_wb_e = 128'(i);     reg_write_wb_e = 1;
            rt_addr_wb_o = 7'(i + 1); rt_wb_o = 128'(i + 1); reg_write_wb_o = 1;
            ra_addr = 7'(i); rb_addr = 7'(i + 1); rc_addr = 7'(127 - i);
            applyStimulus();
        end
        idle();
        ra_addr = 7'd100; rb_addr = 7'd101;
        applyStimulus();
        reset = 1;
        rt_addr_wb_e = 7'd7; rt_wb_e = rand128(); reg_write_wb_e = 1;
        applyStimulus();
        idle();
        for (int i = 0; i < 128; i += 3) begin
            ra_addr = 7'(i);
            rb_addr = 7'((i + 1) % 128);
            rc_addr = 7'((i + 2) % 128);
            applyStimulus();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
